freq_calc: RTL and testbench
============================

# freq_calc

Sequential frequency calculator downstream of the equal-precision gate counter. Watches that counter's gate window, captures the finished reference-clock count M and signal-edge count N, and computes freq = F_REF·N / M with a shift-add multiplier and a restoring divider. Publishes a truncated integer frequency in Hz with a one-cycle valid strobe for the display/readout logic.

## Interface
- F_REF, 50_000_000, reference clock frequency in Hz (must fit in FW bits)
- W, 26, width of M and N
- FW, 26, width of F_REF operand
- QW, 32, width of freq output
- SETTLE, 4, clk cycles waited after gate fall before sampling M/N (≥2)
- clk  in  1  reference clock, same clock that counts M
- rst_n  in  1  reset, asynchronous, active-low
- gate_out  in  1  measurement window from counter (sig_in domain, asynchronous to clk)
- m_in  in  W  reference-clock count M
- n_in  in  W  signal-edge count N
- freq  out  QW  last result, Hz, truncated
- freq_valid  out  1  one-cycle pulse when freq/err update
- busy  out  1  high from fall detection until the DONE cycle inclusive
- err  out  1  status of the last result: 1 = M was zero or quotient saturated

## Operation
- gate_out passes through a 2-FF synchronizer into clk; a third register holds the previous synchronized value. A fall = previous 1, current 0.
- FSM states: IDLE, SETTLE, LATCH, MUL, DIV, DONE.
- IDLE: on a fall → SETTLE, down-counter loaded with SETTLE−1, busy=1.
- SETTLE: count down; at 0 → LATCH. This lets M and N settle after the counter updates them.
- LATCH: capture m_in→m_r and n_in→n_r.
  - m_in==0: skip to DONE with freq=all ones, err=1.
  - Otherwise clear the product register P (W+FW bits) → MUL.
- MUL: W iterations, LSB-first shift-add of F_REF by n_r bits. After W cycles P = F_REF·n_r exactly, no truncation.
- DIV: W+FW iterations of restoring division of P by m_r, MSB-first. Remainder width W+1. Quotient width W+FW. → DONE.
- DONE:
  - If quotient > 2^QW−1: freq = 2^QW−1, err=1.
  - Else freq = quotient[QW−1:0], err=0.
  - freq_valid=1 for this cycle only; then IDLE.
- Falls detected while not in IDLE are ignored. No queuing, and the running computation is unaffected.
- n_r==0 gives freq=0, err=0.
- freq and err hold their value between results.

## Timing
- Reset (async assert, sync to clk on release):
  - freq=0, freq_valid=0, busy=0, err=0.
  - FSM=IDLE; synchronizer and edge registers=0.
  - Internal P, quotient and remainder cleared.
- Reset mid-operation aborts the computation. No freq_valid is issued for it.
- Fall detection: 2–3 clk edges after gate_out falls, depending on phase.
- Latency from the detection edge t0 to the freq_valid cycle: SETTLE + 1 + W + (W+FW) + 1 clk cycles. With defaults that is 84.
- The M=0 path takes SETTLE + 2 cycles.
- busy rises at t0+1 and falls the cycle after freq_valid.
- Throughput: one result per gate window. The gate window must exceed the latency plus 3 cycles, or results are dropped.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- m_in=50_000_000, n_in=1000, one gate fall → one freq_valid 84 cycles after detection, freq=1000, err=0, busy high throughout.
- m_in=3, n_in=1 → freq=16_666_666 (truncated), err=0.
- m_in=1, n_in=100 → quotient 5_000_000_000 saturates: freq=4_294_967_295, err=1.
- m_in=0, n_in=7 → freq=4_294_967_295, err=1, freq_valid at t0+SETTLE+2. Then m_in=10, n_in=0 → freq=0, err=0.
- Second gate fall 20 cycles after the first → exactly one freq_valid, using the first captured M/N. busy does not restart.
- rst_n pulsed low during DIV → outputs 0 immediately, no freq_valid. The next gate fall computes correctly from IDLE.

Source files
------------

// File: rtl/freq_calc.sv
// freq_calc: turns the M/N counts of an equal-precision gate counter into a
// frequency in Hz, freq = F_REF * N / M. A shift-add multiplier is followed by
// a restoring divider. The result is truncated and saturated to QW bits.
module freq_calc #(
    parameter int F_REF  = 50_000_000,
    parameter int W      = 26,
    parameter int FW     = 26,
    parameter int QW     = 32,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gate_out,
    input  logic [W-1:0]  m_in,
    input  logic [W-1:0]  n_in,
    output logic [QW-1:0] freq,
    output logic          freq_valid,
    output logic          busy,
    output logic          err
);

    localparam int PW = W + FW;                 // product / dividend / quotient width
    localparam int CW = $clog2(PW + SETTLE + 1); // one counter serves every phase

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_DIV    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [FW-1:0] F_REF_V = FW'(F_REF);

    logic          gate_meta_reg;
    logic          gate_sync_reg;
    logic          gate_prev_reg;
    logic          gate_fall;

    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  m_reg;
    logic [W-1:0]  n_reg;
    // p_reg holds the product during MUL. During DIV it is the dividend: its
    // MSB is consumed each step and the new quotient bit enters at the LSB, so
    // after PW steps it holds the quotient.
    logic [PW-1:0] p_reg;
    logic [PW-1:0] a_reg;   // multiplicand, shifted left once per MUL step
    logic [W:0]    rem_reg;

    logic [W+1:0]  div_diff;
    logic          div_sub_ok;
    logic [W:0]    rem_next;
    logic [PW-1:0] quo_next;
    logic          quo_sat;

    // Bring the gate window into clk and keep one more stage to spot its fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_meta_reg <= 1'b0;
            gate_sync_reg <= 1'b0;
            gate_prev_reg <= 1'b0;
        end else begin
            gate_meta_reg <= gate_out;
            gate_sync_reg <= gate_meta_reg;
            gate_prev_reg <= gate_sync_reg;
        end
    end

    assign gate_fall = gate_prev_reg & ~gate_sync_reg;

    // One restoring-division step: shift in the next dividend bit and subtract M if it fits
    always_comb begin
        div_diff   = {rem_reg, p_reg[PW-1]} - {2'b00, m_reg};
        div_sub_ok = ~div_diff[W+1];
        rem_next   = div_sub_ok ? div_diff[W:0] : {rem_reg[W-1:0], p_reg[PW-1]};
        quo_next   = {p_reg[PW-2:0], div_sub_ok};
        quo_sat    = |quo_next[PW-1:QW];
    end

    // Sequencer: settle, latch M/N, multiply, divide, publish the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            m_reg      <= '0;
            n_reg      <= '0;
            p_reg      <= '0;
            a_reg      <= '0;
            rem_reg    <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // Falls seen in any other state are dropped on purpose
                    if (gate_fall) begin
                        state_reg <= S_SETTLE;
                        cnt_reg   <= CW'(SETTLE - 1);
                        busy      <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    // Give the upstream counter time to publish its final M/N
                    if (cnt_reg == '0) begin
                        state_reg <= S_LATCH;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_LATCH: begin
                    m_reg <= m_in;
                    n_reg <= n_in;
                    if (m_in == '0) begin
                        // Division by zero: report the error without computing
                        state_reg  <= S_DONE;
                        freq       <= '1;
                        err        <= 1'b1;
                        freq_valid <= 1'b1;
                    end else begin
                        state_reg <= S_MUL;
                        cnt_reg   <= CW'(W - 1);
                        p_reg     <= '0;
                        a_reg     <= {{W{1'b0}}, F_REF_V};
                    end
                end
                S_MUL: begin
                    // LSB-first shift-add; the product never exceeds PW bits
                    if (n_reg[0]) begin
                        p_reg <= p_reg + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    n_reg <= n_reg >> 1;
                    if (cnt_reg == '0) begin
                        state_reg <= S_DIV;
                        cnt_reg   <= CW'(PW - 1);
                        rem_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DIV: begin
                    p_reg   <= quo_next;
                    rem_reg <= rem_next;
                    if (cnt_reg == '0) begin
                        // The last step's quotient goes straight to the output so
                        // freq and freq_valid are both visible in the DONE cycle
                        state_reg  <= S_DONE;
                        freq_valid <= 1'b1;
                        if (quo_sat) begin
                            freq <= '1;
                            err  <= 1'b1;
                        end else begin
                            freq <= quo_next[QW-1:0];
                            err  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_calc.sv
// Testbench for freq_calc. The stimulus pushes the expected result of each
// gate window into a scoreboard queue. A monitor pops that entry whenever the
// DUT pulses freq_valid and compares it.
module tb_freq_calc;

    localparam int W  = 26;
    localparam int QW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gate_out = 1'b0;
    logic [W-1:0]  m_in = '0;
    logic [W-1:0]  n_in = '0;
    logic [QW-1:0] freq;
    logic          freq_valid;
    logic          busy;
    logic          err;

    typedef struct {
        int          id;
        logic [31:0] freq;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    bit   prev_valid = 1'b0;

    freq_calc #(
        .F_REF(50_000_000), .W(26), .FW(26), .QW(32), .SETTLE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .gate_out(gate_out),
        .m_in(m_in),
        .n_in(n_in),
        .freq(freq),
        .freq_valid(freq_valid),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: count busy cycles, compare each published result with the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) check("busy_fall", busy, 0);
            if (busy) busy_cnt++;
            if (freq_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got freq=%0d err=%0d, required no result", freq, err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn %0d: freq=%0d err=%0d latency=%0d (expect %0d/%0d/%0d)",
                             e.id, freq, err, busy_cnt, e.freq, e.err, e.lat);
                    check("freq", freq, e.freq);
                    check("err", err, e.err);
                    check("latency", busy_cnt, e.lat);
                end
                busy_cnt = 0;
            end
            prev_valid = freq_valid;
        end
    end

    // One gate window: high for a few cycles, then a fall between clock edges
    task automatic gate_pulse();
        @(posedge clk); #3 gate_out = 1'b1;
        repeat (4) @(posedge clk);
        #3 gate_out = 1'b0;
    endtask

    task automatic push(input int id, input logic [31:0] f, input logic e, input int lat);
        exp_t x;
        x.id = id; x.freq = f; x.err = e; x.lat = lat;
        sb.push_back(x);
    endtask

    // Wait (bounded) until the monitor has consumed every expected result
    task automatic wait_done(input int id);
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout txn %0d: got no freq_valid, required one within 300 cycles", id);
            sb.delete();
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic run(input int id, input int m, input int n, input logic [31:0] f,
                       input logic e, input int lat);
        m_in = W'(m);
        n_in = W'(n);
        push(id, f, e, lat);
        gate_pulse();
        wait_done(id);
    endtask

    initial begin
        #22;
        check("rst_freq", freq, 0);
        check("rst_valid", freq_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run(1, 50_000_000, 1000, 32'd1000, 1'b0, 84);
        run(2, 3, 1, 32'd16_666_666, 1'b0, 84);
        run(3, 1, 100, 32'hFFFF_FFFF, 1'b1, 84);

        // Reset in the middle of DIV: outputs clear at once, no result appears
        begin
            int k = 0;
            m_in = W'(50_000_000);
            n_in = W'(1000);
            gate_pulse();
            while (!busy && k < 20) begin
                @(posedge clk);
                k++;
            end
            check("busy_rise", busy, 1);
            repeat (45) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check("abort_freq", freq, 0);
            check("abort_err", err, 0);
            check("abort_busy", busy, 0);
            check("abort_valid", freq_valid, 0);
            @(posedge clk); #2 rst_n = 1'b1;
            repeat (100) @(posedge clk);
            check("abort_busy_after", busy, 0);
        end

        run(4, 0, 7, 32'hFFFF_FFFF, 1'b1, 6);
        run(5, 10, 0, 32'd0, 1'b0, 84);

        // Second fall 20 cycles after the first is ignored; captured M/N are used
        m_in = W'(50_000_000);
        n_in = W'(1000);
        push(6, 32'd1000, 1'b0, 84);
        gate_pulse();
        repeat (10) @(posedge clk);
        m_in = W'(3);
        n_in = W'(1);
        repeat (5) @(posedge clk);
        #3 gate_out = 1'b1;
        repeat (5) @(posedge clk);
        #3 gate_out = 1'b0;
        wait_done(6);
        repeat (150) @(posedge clk);
        check("no_restart_busy", busy, 0);

        run(7, 3, 1, 32'd16_666_666, 1'b0, 84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
